// File: rtl/spi_ram_ctrl.sv
// Command sequencer between the SPI slave and a single-port RAM: decodes 10-bit words into
// address-latch, write and read operations. Optional macro AUTO_INC_EN enables address auto-increment.
module spi_ram_ctrl #(
   parameter int ADDR_SIZE = 8,
   parameter int MEM_DEPTH = 256,
   parameter int RD_LAT    = 1,
   parameter int TX_HOLD   = 9
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [9:0]           rx_data,
   input  logic                 rx_valid,
   output logic [7:0]           tx_data,
   output logic                 tx_valid,
   output logic [ADDR_SIZE-1:0] ram_addr,
   output logic [7:0]           ram_wdata,
   output logic                 ram_we,
   output logic                 ram_re,
   input  logic [7:0]           ram_rdata,
   output logic                 busy,
   output logic                 seq_err
);
   localparam int CNT_W = $clog2(RD_LAT + TX_HOLD + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      TX      = 2'd2
   } state_t;

   // Wrap-around arithmetic relies on the address width covering the whole RAM exactly.
   if (MEM_DEPTH != (1 << ADDR_SIZE)) begin : g_depth_check
      $error("MEM_DEPTH must equal 2**ADDR_SIZE");
   end

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
   logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
   logic                 rd_addr_ok_q, rd_addr_ok_d;
   logic [ADDR_SIZE-1:0] ram_addr_q, ram_addr_d;
   logic [7:0]           ram_wdata_q, ram_wdata_d;
   logic                 ram_we_q, ram_we_d;
   logic                 ram_re_q, ram_re_d;
   logic [7:0]           tx_data_q, tx_data_d;
   logic                 tx_valid_q, tx_valid_d;
   logic                 seq_err_q, seq_err_d;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      wr_addr_d    = wr_addr_q;
      rd_addr_d    = rd_addr_q;
      rd_addr_ok_d = rd_addr_ok_q;
      ram_addr_d   = ram_addr_q;
      ram_wdata_d  = ram_wdata_q;
      ram_we_d     = 1'b0;
      ram_re_d     = 1'b0;
      tx_data_d    = tx_data_q;
      tx_valid_d   = tx_valid_q;
      seq_err_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (rx_valid) begin
               case (rx_data[9:8])
                  2'b00: wr_addr_d = rx_data[ADDR_SIZE-1:0];
                  2'b01: begin
                     ram_we_d    = 1'b1;
                     ram_addr_d  = wr_addr_q;
                     ram_wdata_d = rx_data[7:0];
`ifdef AUTO_INC_EN
                     wr_addr_d   = wr_addr_q + ADDR_SIZE'(1);
`endif
                  end
                  2'b10: begin
                     rd_addr_d    = rx_data[ADDR_SIZE-1:0];
                     rd_addr_ok_d = 1'b1;
                  end
                  default: begin
                     if (rd_addr_ok_q) begin
                        ram_re_d   = 1'b1;
                        ram_addr_d = rd_addr_q;
                        cnt_d      = '0;
                        state_d    = RD_WAIT;
`ifdef AUTO_INC_EN
                        rd_addr_d  = rd_addr_q + ADDR_SIZE'(1);
`endif
                     end else begin
                        seq_err_d = 1'b1;
                     end
                  end
               endcase
            end
         end
         // cnt_q==0 is the ram_re cycle, so read data is valid when the count reaches RD_LAT.
         RD_WAIT: begin
            if (cnt_q == CNT_W'(RD_LAT)) begin
               tx_data_d  = ram_rdata;
               tx_valid_d = 1'b1;
               cnt_d      = '0;
               state_d    = TX;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         TX: begin
            if (cnt_q == CNT_W'(TX_HOLD - 1)) begin
               tx_valid_d = 1'b0;
               cnt_d      = '0;
               state_d    = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // Words arriving while a read is in flight are dropped and flagged.
      if (rx_valid && (state_q != IDLE)) begin
         seq_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         wr_addr_q    <= '0;
         rd_addr_q    <= '0;
         rd_addr_ok_q <= 1'b0;
         ram_addr_q   <= '0;
         ram_wdata_q  <= '0;
         ram_we_q     <= 1'b0;
         ram_re_q     <= 1'b0;
         tx_data_q    <= '0;
         tx_valid_q   <= 1'b0;
         seq_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         wr_addr_q    <= wr_addr_d;
         rd_addr_q    <= rd_addr_d;
         rd_addr_ok_q <= rd_addr_ok_d;
         ram_addr_q   <= ram_addr_d;
         ram_wdata_q  <= ram_wdata_d;
         ram_we_q     <= ram_we_d;
         ram_re_q     <= ram_re_d;
         tx_data_q    <= tx_data_d;
         tx_valid_q   <= tx_valid_d;
         seq_err_q    <= seq_err_d;
      end
   end

   assign tx_data   = tx_data_q;
   assign tx_valid  = tx_valid_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;
   assign ram_we    = ram_we_q;
   assign ram_re    = ram_re_q;
   assign seq_err   = seq_err_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Self-checking bench for spi_ram_ctrl: two instances (RD_LAT=1 and RD_LAT=3) share one
// command stream; results are compared against a command-level reference model.
module tb_spi_ram_ctrl;
   logic       clk;
   logic       rst;
   logic [9:0] rx_data;
   logic       rx_valid;

   logic [7:0] tx_data_a, ram_wdata_a, ram_rdata_a, ram_addr_a;
   logic       tx_valid_a, ram_we_a, ram_re_a, busy_a, seq_err_a;
   logic [7:0] tx_data_b, ram_wdata_b, ram_rdata_b, ram_addr_b;
   logic       tx_valid_b, ram_we_b, ram_re_b, busy_b, seq_err_b;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   spi_ram_ctrl #(.ADDR_SIZE(8), .MEM_DEPTH(256), .RD_LAT(1), .TX_HOLD(9)) dut_a (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data_a), .tx_valid(tx_valid_a), .ram_addr(ram_addr_a),
      .ram_wdata(ram_wdata_a), .ram_we(ram_we_a), .ram_re(ram_re_a),
      .ram_rdata(ram_rdata_a), .busy(busy_a), .seq_err(seq_err_a)
   );

   spi_ram_ctrl #(.ADDR_SIZE(8), .MEM_DEPTH(256), .RD_LAT(3), .TX_HOLD(9)) dut_b (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data_b), .tx_valid(tx_valid_b), .ram_addr(ram_addr_b),
      .ram_wdata(ram_wdata_b), .ram_we(ram_we_b), .ram_re(ram_re_b),
      .ram_rdata(ram_rdata_b), .busy(busy_b), .seq_err(seq_err_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // RAM environment: preload port plus DUT port, read data delayed by the instance's RD_LAT.
   logic       load;
   logic [7:0] load_addr, load_data;
   logic [7:0] mem_a [0:255];
   logic [7:0] mem_b [0:255];
   logic [7:0] pipe_a;
   logic [7:0] pipe_b [0:2];

   always @(posedge clk) begin
      if (load) begin
         mem_a[load_addr] <= load_data;
         mem_b[load_addr] <= load_data;
      end else begin
         if (ram_we_a) mem_a[ram_addr_a] <= ram_wdata_a;
         if (ram_we_b) mem_b[ram_addr_b] <= ram_wdata_b;
      end
      pipe_a    <= ram_re_a ? mem_a[ram_addr_a] : 8'hxx;
      pipe_b[0] <= ram_re_b ? mem_b[ram_addr_b] : 8'hxx;
      pipe_b[1] <= pipe_b[0];
      pipe_b[2] <= pipe_b[1];
   end
   assign ram_rdata_a = pipe_a;
   assign ram_rdata_b = pipe_b[2];

   // Reference model: expected memory image and address registers.
   logic [7:0] mem_model [0:255];
   int         m_wr, m_rd;
   bit         m_ok, m_read_issued;
   logic [7:0] m_last_rd;
   int         last_acc;
   logic [1:0] rc;
   logic [7:0] rp;
   int         n_acc;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [1:0] cmd, input logic [7:0] p);
      logic       e_we, e_re, e_err;
      logic [7:0] e_addr;
      e_we = 1'b0; e_re = 1'b0; e_err = 1'b0; e_addr = 8'h00;
      m_read_issued = 1'b0;
      case (cmd)
         2'd0: m_wr = int'(p);
         2'd1: begin
            e_we = 1'b1;
            e_addr = 8'(m_wr);
            mem_model[m_wr] = p;
`ifdef AUTO_INC_EN
            m_wr = (m_wr + 1) % 256;
`endif
         end
         2'd2: begin
            m_rd = int'(p);
            m_ok = 1'b1;
         end
         default: begin
            if (m_ok) begin
               e_re = 1'b1;
               e_addr = 8'(m_rd);
               m_last_rd = mem_model[m_rd];
               m_read_issued = 1'b1;
`ifdef AUTO_INC_EN
               m_rd = (m_rd + 1) % 256;
`endif
            end else begin
               e_err = 1'b1;
            end
         end
      endcase
      rx_data = {cmd, p};
      rx_valid = 1'b1;
      last_acc = cyc;
      tick();
      rx_valid = 1'b0;
      $display("cmd=%0d payload=%02h we=%0b re=%0b addr=%02h wdata=%02h seq_err=%0b",
               cmd, p, ram_we_a, ram_re_a, ram_addr_a, ram_wdata_a, seq_err_a);
      check("ram_we", ram_we_a, e_we);
      check("ram_re", ram_re_a, e_re);
      check("seq_err", seq_err_a, e_err);
      if (e_we || e_re) check("ram_addr", ram_addr_a, e_addr);
      if (e_we) check("ram_wdata", ram_wdata_a, p);
   endtask

   // Observe both tx windows after a read accepted at cycle acc; optionally inject a WR_DATA.
   task automatic watch(input int acc, input logic [7:0] exp, input int drop_off);
      int rise_a, rise_b, hi_a, hi_b;
      bit bad_a, bad_b, drop_now;
      rise_a = -1; rise_b = -1; hi_a = 0; hi_b = 0; bad_a = 1'b0; bad_b = 1'b0;
      for (int i = 0; i < 22; i++) begin
         if (tx_valid_a) begin
            if (rise_a < 0) rise_a = cyc;
            hi_a++;
            if (tx_data_a !== exp) bad_a = 1'b1;
         end
         if (tx_valid_b) begin
            if (rise_b < 0) rise_b = cyc;
            hi_b++;
            if (tx_data_b !== exp) bad_b = 1'b1;
         end
         drop_now = (drop_off >= 0) && (cyc == acc + drop_off);
         if (drop_now) begin
            rx_data = {2'b01, 8'h77};
            rx_valid = 1'b1;
         end
         tick();
         rx_valid = 1'b0;
         if (drop_now) begin
            check("drop_seq_err_a", seq_err_a, 1);
            check("drop_seq_err_b", seq_err_b, 1);
            check("drop_no_we", ram_we_a, 0);
         end
      end
      $display("read acc=%0d exp=%02h rise_a=%0d hi_a=%0d rise_b=%0d hi_b=%0d tx_a=%02h tx_b=%02h",
               acc, exp, rise_a, hi_a, rise_b, hi_b, tx_data_a, tx_data_b);
      check("tx_rise_a", rise_a, acc + 3);
      check("tx_rise_b", rise_b, acc + 5);
      check("tx_hold_a", hi_a, 9);
      check("tx_hold_b", hi_b, 9);
      check("tx_data_a", bad_a, 0);
      check("tx_data_b", bad_b, 0);
      check("busy_end_a", busy_a, 0);
      check("busy_end_b", busy_b, 0);
   endtask

   initial begin
      rst = 1'b1; rx_valid = 1'b0; rx_data = '0;
      load = 1'b0; load_addr = '0; load_data = '0;
      m_wr = 0; m_rd = 0; m_ok = 1'b0; m_last_rd = '0; m_read_issued = 1'b0;
      tick();
      for (int i = 0; i < 256; i++) begin
         load = 1'b1;
         load_addr = 8'(i);
         load_data = 8'($urandom);
         mem_model[i] = load_data;
         tick();
      end
      load = 1'b0;

      // Reset state
      check("rst_tx_valid", tx_valid_a, 0);
      check("rst_tx_data", tx_data_a, 0);
      check("rst_ram_addr", ram_addr_a, 0);
      check("rst_ram_wdata", ram_wdata_a, 0);
      check("rst_ram_we", ram_we_a, 0);
      check("rst_ram_re", ram_re_a, 0);
      check("rst_busy", busy_a, 0);
      check("rst_seq_err", seq_err_a, 0);
      check("rst_busy_b", busy_b, 0);
      rst = 1'b0;
      tick();

      // Read without an address
      send(2'd3, 8'h00);
      tick();
      check("seq_err_pulse_end", seq_err_a, 0);
      check("noaddr_tx_valid", tx_valid_a, 0);
      check("noaddr_busy", busy_a, 0);

      // Write then read back
      send(2'd0, 8'h12);
      send(2'd1, 8'hA5);
      send(2'd2, 8'h12);
      send(2'd3, 8'h00);
      watch(last_acc, m_last_rd, -1);

      // Command dropped during the tx window
      send(2'd2, 8'h03);
      send(2'd3, 8'h00);
      watch(last_acc, m_last_rd, 5);

      // Reset on the 4th tx_valid cycle
      send(2'd2, 8'h40);
      send(2'd3, 8'h00);
      n_acc = last_acc;
      for (int i = 0; i < 8 && cyc < n_acc + 6; i++) tick();
      check("abort_tx_on", tx_valid_a, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_wr = 0; m_rd = 0; m_ok = 1'b0;
      check("abort_tx_valid_a", tx_valid_a, 0);
      check("abort_busy_a", busy_a, 0);
      check("abort_tx_valid_b", tx_valid_b, 0);
      check("abort_busy_b", busy_b, 0);
      send(2'd3, 8'h00);
      tick();
      check("abort_no_tx", tx_valid_a, 0);

      // Address wrap / overwrite burst
      send(2'd0, 8'hFF);
      send(2'd1, 8'h11);
      send(2'd1, 8'h22);
      send(2'd2, 8'hFF);
      send(2'd3, 8'h00);
      watch(last_acc, m_last_rd, -1);
      send(2'd3, 8'h00);
      watch(last_acc, m_last_rd, -1);

      // Random command stream
      for (int it = 0; it < 40; it++) begin
         rc = 2'($urandom_range(0, 3));
         rp = (rc == 2'd0 || rc == 2'd2) ? 8'($urandom_range(0, 15)) : 8'($urandom);
         send(rc, rp);
         if (m_read_issued) watch(last_acc, m_last_rd, -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
